// File: rtl/sid_voice_multi.sv
// SID voice with master plus detuned companion phase accumulators, classic waveforms, supersaw and DCA.
// Define SID_NOISE_WRITEBACK_EN to model the 8580 noise LFSR lock-up when noise is combined with other waves.
module sid_voice_multi #(
    parameter int ACC_W   = 24,
    parameter int WAVE_W  = 12,
    parameter int NUM_OSC = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ce_1m,
    input  logic [15:0]              freq,
    input  logic [11:0]              pw,
    input  logic [7:0]               control,
    input  logic [7:0]               detune,
    input  logic [7:0]               envelope,
    input  logic                     osc_msb_in,
    output logic                     osc_msb_out,
    output logic [WAVE_W-1:0]        wave_out,
    output logic signed [WAVE_W-1:0] signal_out,
    output logic [7:0]               osc_out,
    output logic                     sum_overrun
);

    localparam int LOG_OSC = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 0;
    localparam int IDX_W   = (NUM_OSC > 1) ? LOG_OSC : 1;
    localparam int SUM_W   = WAVE_W + LOG_OSC;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SUM  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [ACC_W-1:0]         acc_q [NUM_OSC];
    logic [ACC_W-1:0]         acc_d [NUM_OSC];
    logic                     msb_in_q, msb_in_d;
    logic                     osc_edge_q, osc_edge_d;
    logic [22:0]              lfsr_q, lfsr_d;
    logic [1:0]               state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [WAVE_W-1:0]        wave_out_q, wave_out_d;
    logic signed [WAVE_W-1:0] signal_q, signal_d;
    logic                     sum_overrun_q, sum_overrun_d;

    logic                     test_bit, sync_load, edge_bit;
    logic [22:0]              lfsr_src;
    logic [WAVE_W-1:0]        saw_w, tri_w, pul_w, noi_w, ss_w, sel_w;
    logic                     tri_msb;
    logic [7:0]               noise_taps;
    logic [WAVE_W+7:0]        prod;
    logic                     gate_unused;

    assign gate_unused = control[0];
    assign test_bit    = control[3];
    // Hard sync fires on a 1->0 transition of the neighbour MSB between strobes.
    assign sync_load   = test_bit | (control[1] & msb_in_q & ~osc_msb_in);

    always_comb begin
        for (int k = 0; k < NUM_OSC; k++) begin
            acc_d[k] = acc_q[k];
            if (ce_1m) begin
                if (sync_load) acc_d[k] = '1;
                else acc_d[k] = acc_q[k] + ACC_W'(freq) + ACC_W'(k * int'(detune));
            end
        end
        msb_in_d = ce_1m ? osc_msb_in : msb_in_q;
    end

    // LFSR clocks on the rising edge of the post-update master bit ACC_W-5.
    assign edge_bit = acc_d[0][ACC_W-5];

    always_comb begin
        lfsr_src = lfsr_q;
`ifdef SID_NOISE_WRITEBACK_EN
        if (control[7] && (control[6:4] != 3'b000)) begin
            lfsr_src[20] = lfsr_q[20] & wave_out_q[WAVE_W-1];
            lfsr_src[18] = lfsr_q[18] & wave_out_q[WAVE_W-2];
            lfsr_src[14] = lfsr_q[14] & wave_out_q[WAVE_W-3];
            lfsr_src[11] = lfsr_q[11] & wave_out_q[WAVE_W-4];
            lfsr_src[9]  = lfsr_q[9]  & wave_out_q[WAVE_W-5];
            lfsr_src[5]  = lfsr_q[5]  & wave_out_q[WAVE_W-6];
            lfsr_src[2]  = lfsr_q[2]  & wave_out_q[WAVE_W-7];
            lfsr_src[0]  = lfsr_q[0]  & wave_out_q[WAVE_W-8];
        end
`endif
        lfsr_d     = lfsr_q;
        osc_edge_d = osc_edge_q;
        if (ce_1m) begin
            osc_edge_d = edge_bit;
            if (edge_bit && !osc_edge_q)
                lfsr_d = {lfsr_src[21:0], lfsr_src[22] ^ lfsr_src[17] ^ test_bit};
        end
    end

    always_comb begin
        saw_w      = acc_q[0][ACC_W-1 -: WAVE_W];
        tri_msb    = acc_q[0][ACC_W-1] ^ (control[2] & osc_msb_in);
        tri_w      = {{(WAVE_W-1){tri_msb}} ^ acc_q[0][ACC_W-2 -: WAVE_W-1], 1'b0};
        pul_w      = (test_bit || (acc_q[0][ACC_W-1 -: 12] >= pw)) ? '1 : '0;
        noise_taps = {lfsr_q[20], lfsr_q[18], lfsr_q[14], lfsr_q[11],
                      lfsr_q[9], lfsr_q[5], lfsr_q[2], lfsr_q[0]};
        noi_w      = WAVE_W'(noise_taps) << (WAVE_W - 8);
        ss_w       = WAVE_W'(sum_q >> LOG_OSC);
        case (control[7:4])
            4'b0001: sel_w = tri_w;
            4'b0010: sel_w = saw_w;
            4'b0100: sel_w = pul_w;
            4'b1000: sel_w = noi_w;
            4'b1010: sel_w = ss_w;
            4'b0011: sel_w = tri_w & saw_w;
            4'b0101: sel_w = tri_w & pul_w;
            4'b0110: sel_w = saw_w & pul_w;
            4'b0111: sel_w = tri_w & saw_w & pul_w;
            default: sel_w = '0;
        endcase
    end

    // Supersaw sequencer: one accumulator per clock, then a single DONE clock that latches the output.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        wave_out_d    = wave_out_q;
        sum_overrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce_1m) begin
                    state_d = ST_SUM;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            ST_SUM, ST_DONE: begin
                if (ce_1m) begin
                    sum_overrun_d = 1'b1;
                    state_d       = ST_SUM;
                    idx_d         = '0;
                    sum_d         = '0;
                end else if (state_q == ST_SUM) begin
                    sum_d = sum_q + SUM_W'(acc_q[idx_q][ACC_W-1 -: WAVE_W]);
                    if (idx_q == IDX_W'(NUM_OSC - 1)) state_d = ST_DONE;
                    else idx_d = idx_q + 1'b1;
                end else begin
                    wave_out_d = sel_w;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign prod     = (WAVE_W+8)'(wave_out_q) * (WAVE_W+8)'(envelope);
    assign signal_d = signed'(WAVE_W'(prod >> 8));

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_OSC; k++) acc_q[k] <= '1;
            msb_in_q      <= 1'b0;
            osc_edge_q    <= 1'b0;
            lfsr_q        <= 23'h1;
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            sum_q         <= '0;
            wave_out_q    <= '0;
            signal_q      <= '0;
            sum_overrun_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_OSC; k++) acc_q[k] <= acc_d[k];
            msb_in_q      <= msb_in_d;
            osc_edge_q    <= osc_edge_d;
            lfsr_q        <= lfsr_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            wave_out_q    <= wave_out_d;
            signal_q      <= signal_d;
            sum_overrun_q <= sum_overrun_d;
        end
    end

    assign osc_msb_out = acc_q[0][ACC_W-1];
    assign wave_out    = wave_out_q;
    assign signal_out  = signal_q;
    assign osc_out     = wave_out_q[WAVE_W-1 -: 8];
    assign sum_overrun = sum_overrun_q;

endmodule

// File: tb/tb_sid_voice_multi.sv
// Directed bench for sid_voice_multi at default parameters (ACC_W=24, WAVE_W=12, NUM_OSC=4).
module tb_sid_voice_multi;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ce_1m = 1'b0;
    logic [15:0]        freq = '0;
    logic [11:0]        pw = '0;
    logic [7:0]         control = '0;
    logic [7:0]         detune = '0;
    logic [7:0]         envelope = '0;
    logic               osc_msb_in = 1'b0;
    logic               osc_msb_out;
    logic [11:0]        wave_out;
    logic signed [11:0] signal_out;
    logic [7:0]         osc_out;
    logic               sum_overrun;

    int checks = 0;
    int errors = 0;

    sid_voice_multi dut (
        .clock       (clock),
        .reset       (reset),
        .ce_1m       (ce_1m),
        .freq        (freq),
        .pw          (pw),
        .control     (control),
        .detune      (detune),
        .envelope    (envelope),
        .osc_msb_in  (osc_msb_in),
        .osc_msb_out (osc_msb_out),
        .wave_out    (wave_out),
        .signal_out  (signal_out),
        .osc_out     (osc_out),
        .sum_overrun (sum_overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic pulse_ce();
        @(negedge clock);
        ce_1m = 1'b1;
        @(negedge clock);
        ce_1m = 1'b0;
    endtask

    task automatic strobe();
        pulse_ce();
        repeat (8) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk("rst_wave", wave_out, 12'h000);
        chk("rst_signal", $unsigned(signal_out), 12'h000);
        chk("rst_overrun", sum_overrun, 1'b0);
        chk("rst_msb", osc_msb_out, 1'b1);

        // Sawtooth ramp from the all-ones reset value
        freq = 16'h1000; control = 8'h20;
        for (int n = 1; n <= 16; n++) begin
            strobe();
            chk($sformatf("saw_%0d", n), wave_out, 32'(n - 1));
        end
        chk("saw_sig_env0", $unsigned(signal_out), 12'h000);

        // Pulse around pw=0x800 with full envelope, including output latency
        do_reset();
        freq = 16'h8000; control = 8'h40; pw = 12'h800; envelope = 8'hFF;
        for (int n = 1; n <= 256; n++) strobe();
        chk("pul_256", wave_out, 12'h000);
        chk("pul_256_sig", $unsigned(signal_out), 12'h000);
        pulse_ce();
        repeat (4) @(negedge clock);
        chk("lat_wave_old", wave_out, 12'h000);
        @(negedge clock);
        chk("lat_wave_new", wave_out, 12'hFFF);
        chk("lat_sig_old", $unsigned(signal_out), 12'h000);
        @(negedge clock);
        chk("lat_sig_new", $unsigned(signal_out), 12'hFEF);
        chk("pul_osc_out", osc_out, 8'hFF);
        repeat (3) @(negedge clock);
        for (int n = 258; n <= 512; n++) strobe();
        chk("pul_512", wave_out, 12'hFFF);
        strobe();
        chk("pul_513", wave_out, 12'h000);
        envelope = 8'h00;

        // Supersaw with detune: acc[k] = 0x1000*k - 1 after 256 strobes
        do_reset();
        freq = 16'h0000; detune = 8'h10; control = 8'hA0;
        strobe();
        chk("ss_det_1", wave_out, 12'h3FF);
        for (int n = 2; n <= 256; n++) strobe();
        chk("ss_det_256", wave_out, 12'h400);

        // Overrun: second strobe two clocks after the first; detune 0 makes supersaw == saw
        do_reset();
        freq = 16'h1000; detune = 8'h00; control = 8'hA0;
        strobe();
        strobe();
        chk("ss_eq_saw", wave_out, 12'h001);
        pulse_ce();
        @(negedge clock);
        ce_1m = 1'b1;
        @(negedge clock);
        ce_1m = 1'b0;
        chk("ovr_pulse", sum_overrun, 1'b1);
        @(negedge clock);
        chk("ovr_clear", sum_overrun, 1'b0);
        repeat (3) @(negedge clock);
        chk("ovr_hold", wave_out, 12'h001);
        @(negedge clock);
        chk("ovr_resume", wave_out, 12'h003);
        strobe();
        chk("ovr_next", wave_out, 12'h004);

        // Hard sync on a falling neighbour MSB
        do_reset();
        freq = 16'h1000; control = 8'h22; osc_msb_in = 1'b1;
        repeat (3) strobe();
        chk("sync_pre", wave_out, 12'h002);
        osc_msb_in = 1'b0;
        strobe();
        chk("sync_load", wave_out, 12'hFFF);
        chk("sync_msb", osc_msb_out, 1'b1);
        strobe();
        chk("sync_after", wave_out, 12'h000);

        // Triangle, combined, ring and an unsupported code
        do_reset();
        freq = 16'hF000; osc_msb_in = 1'b0;
        control = 8'h10; strobe();
        chk("tri", wave_out, 12'h01C);
        control = 8'h30; strobe();
        chk("tri_and_saw", wave_out, 12'h018);
        control = 8'h14; osc_msb_in = 1'b1; strobe();
        chk("tri_ring", wave_out, 12'hFA6);
        chk("tri_ring_osc", osc_out, 8'hFA);
        control = 8'h90; strobe();
        chk("bad_code", wave_out, 12'h000);
        osc_msb_in = 1'b0;

        // Test bit: hold accumulators, force pulse, feed a one into the LFSR
        do_reset();
        freq = 16'h1000; pw = 12'h800; control = 8'h48;
        for (int n = 1; n <= 3; n++) begin
            strobe();
            chk($sformatf("test_pul_%0d", n), wave_out, 12'hFFF);
            chk($sformatf("test_msb_%0d", n), osc_msb_out, 1'b1);
        end
        control = 8'h88; strobe();
        chk("test_noise", wave_out, 12'h010);
        freq = 16'hFFFF; control = 8'h80;
        strobe();
        chk("noise_msb", osc_msb_out, 1'b0);
        for (int n = 2; n <= 9; n++) strobe();
        chk("noise_shift", wave_out, 12'h020);

        // Reset while summing
        do_reset();
        freq = 16'h1000; control = 8'h20;
        repeat (3) strobe();
        chk("mid_pre", wave_out, 12'h002);
        pulse_ce();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_wave", wave_out, 12'h000);
        chk("mid_overrun", sum_overrun, 1'b0);
        chk("mid_msb", osc_msb_out, 1'b1);
        repeat (8) @(negedge clock);
        chk("mid_idle", wave_out, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
